rng_sum_sequencer: RTL and testbench

- Controller that sequences the random-sample datapath: random number generator, then divide-by-three, then three-sample accumulation.
- On a start request it performs three sample cycles:
  - pulses the generator;
  - waits for the generator's latency;
  - captures the sample and presents it to the divider;
  - accumulates the divider's quotient.
- It then presents the sum with a valid/ready handshake.
- Replaces free-running start/sum behaviour with deterministic, countable operation.

---
 rtl/rng_sum_sequencer_pkg.sv | 12 +
 rtl/rng_sum_sequencer_edge_detect.sv | 13 +
 rtl/rng_sum_sequencer.sv | 67 ++++++
 tb/tb_rng_sum_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rng_sum_sequencer_pkg.sv
// rng_sum_sequencer_pkg: shared state encodings and default widths for the sample sequencer
package rng_sum_sequencer_pkg;
  localparam logic [2:0] SEQ_IDLE = 3'd0;
  localparam logic [2:0] SEQ_REQ  = 3'd1;
  localparam logic [2:0] SEQ_WAIT = 3'd2;
  localparam logic [2:0] SEQ_ACC  = 3'd3;
  localparam logic [2:0] SEQ_DONE = 3'd4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_NUM_SAMPLES = 3;
  localparam int DEF_SUM_W       = 10;
  localparam int DEF_RNG_LAT     = 1;
endpackage

// File: rtl/rng_sum_sequencer_edge_detect.sv
// edge_detect: registered rising-edge detector with async active-low reset
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= in;
  assign rise = in & ~q;
endmodule

// File: rtl/rng_sum_sequencer.sv
// rng_sum_sequencer: runs NUM_SAMPLES generator/divider cycles per start edge and hands off the quotient sum
module rng_sum_sequencer
  import rng_sum_sequencer_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int SUM_W       = DEF_SUM_W,
  parameter int RNG_LAT     = DEF_RNG_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rng_start,
  input  logic [DATA_W-1:0] rng_data,
  output logic [DATA_W-1:0] div_dividend,
  input  logic [DATA_W-1:0] div_quotient,
  output logic [SUM_W-1:0]  sum_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        sample_cnt
);
  localparam int CNT_W = RNG_LAT > 1 ? $clog2(RNG_LAT) : 1;
  logic [2:0] state;
  logic [CNT_W-1:0] wait_cnt;
  logic start_edge;
  edge_detect u_start (.clk(clk), .rst(rst), .in(start), .rise(start_edge));
  assign rng_start = state == SEQ_REQ;
  assign out_valid = state == SEQ_DONE;
  assign busy      = state != SEQ_IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= SEQ_IDLE;
      wait_cnt     <= '0;
      sum_out      <= '0;
      div_dividend <= '0;
      sample_cnt   <= '0;
    end else begin
      case (state)
        SEQ_IDLE:
          if (start_edge) begin
            sum_out    <= '0;
            sample_cnt <= '0;
            state      <= SEQ_REQ;
          end
        SEQ_REQ: begin
          wait_cnt <= CNT_W'(RNG_LAT - 1);
          state    <= SEQ_WAIT;
        end
        SEQ_WAIT:
          if (wait_cnt == '0) begin
            div_dividend <= rng_data;
            state        <= SEQ_ACC;
          end else wait_cnt <= wait_cnt - 1'b1;
        SEQ_ACC: begin
          sum_out <= sum_out + SUM_W'(div_quotient);
          if (sample_cnt == 2'(NUM_SAMPLES - 1)) state <= SEQ_DONE;
          else begin
            sample_cnt <= sample_cnt + 2'd1;
            state      <= SEQ_REQ;
          end
        end
        SEQ_DONE: if (out_ready) state <= SEQ_IDLE;
        default: state <= SEQ_IDLE;
      endcase
    end
endmodule

// File: tb/tb_rng_sum_sequencer.sv
// tb_rng_sum_sequencer: directed and random checks of the sequencer against a sum-of-thirds model
module tb_rng_sum_sequencer;
  logic clk = 0, rst = 0, start = 0, out_ready = 0, start3 = 0, ready3 = 0;
  logic rng_start, out_valid, busy, rng_start3, out_valid3, busy3;
  logic [7:0] rng_data, div_dividend, div_quotient, rng_data3, div_dividend3, div_quotient3;
  logic [9:0] sum_out, sum_out3;
  logic [1:0] sample_cnt, sample_cnt3;
  int vectors = 0, miscompares = 0, pulses = 0, wide = 0, stray = 0, vseen = 0, g3cnt = 0;
  logic prev_pulse = 0;
  logic [7:0] gq[$], gq3[$], g3val;

  rng_sum_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .rng_start(rng_start), .rng_data(rng_data),
    .div_dividend(div_dividend), .div_quotient(div_quotient), .sum_out(sum_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .sample_cnt(sample_cnt));
  rng_sum_sequencer #(.RNG_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .rng_start(rng_start3), .rng_data(rng_data3),
    .div_dividend(div_dividend3), .div_quotient(div_quotient3), .sum_out(sum_out3),
    .out_valid(out_valid3), .out_ready(ready3), .busy(busy3), .sample_cnt(sample_cnt3));

  always #5 clk = ~clk;
  assign div_quotient  = div_dividend / 8'd3;
  assign div_quotient3 = div_dividend3 / 8'd3;

  // generator model, latency 1: next value appears the cycle after the pulse
  always @(posedge clk or negedge rst)
    if (!rst) rng_data <= 8'h00;
    else if (rng_start) rng_data <= (gq.size() > 0) ? gq.pop_front() : 8'h00;

  // generator model, latency 3: output is garbage (inverted value) until the data is due
  always @(posedge clk)
    if (!rst) g3cnt = 0;
    else if (rng_start3) begin
      g3val = (gq3.size() > 0) ? gq3.pop_front() : 8'h00;
      rng_data3 <= ~g3val;
      g3cnt = 2;
    end else if (g3cnt > 0) begin
      g3cnt--;
      if (g3cnt == 0) rng_data3 <= g3val;
    end

  always @(posedge clk) begin
    if (rng_start) begin
      pulses++;
      if (prev_pulse) wide++;
      if (!busy) stray++;
    end
    if (out_valid) vseen++;
    prev_pulse = rng_start;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input int hold, input string tag);
    int e, k, p0, bad;
    logic [7:0] dv[$];
    logic [9:0] s0;
    e = (int'(a) / 3 + int'(b) / 3 + int'(c) / 3) % 1024;
    gq = '{a, b, c};
    p0 = pulses;
    start = 1;
    step();
    k = 1;
    while (!out_valid && k < 100) begin
      if (k % 3 == 0) dv.push_back(div_dividend);
      step();
      k++;
    end
    chk({tag, "_latency"}, k, 10);
    chk({tag, "_sum"}, sum_out, e);
    chk({tag, "_pulses"}, pulses - p0, 3);
    chk({tag, "_dividends"}, (dv.size() == 3) ? {8'h0, dv[0], dv[1], dv[2]} : 32'hffffffff,
        {8'h0, a, b, c});
    s0 = sum_out;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!out_valid || sum_out !== s0 || !busy) bad++;
    end
    if (hold > 0) begin
      chk({tag, "_hold_stable"}, bad, 0);
      chk({tag, "_hold_pulses"}, pulses - p0, 3);
    end
    out_ready = 1;
    step();
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_sum_kept"}, sum_out, e);
    out_ready = 0;
    start = 0;
    step();
  endtask

  initial begin
    int k, p0, bad, v0;
    logic [7:0] a, b, c;
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", rng_start, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_div", div_dividend, 0);
    chk("rst_cnt", sample_cnt, 0);
    step();
    step();
    rst = 1;
    out_ready = 1;
    repeat (3) step();
    chk("ready_in_idle", {busy, out_valid}, 0);
    out_ready = 0;
    step();

    run_op(8'd30, 8'd60, 8'd90, 0, "basic");
    run_op(8'd255, 8'd255, 8'd255, 0, "max");

    gq3 = '{8'd255, 8'd255, 8'd255};
    start3 = 1;
    step();
    k = 1;
    while (!out_valid3 && k < 100) begin
      step();
      k++;
    end
    chk("lat3_latency", k, 16);
    chk("lat3_sum", sum_out3, 255);
    ready3 = 1;
    step();
    chk("lat3_valid_drop", out_valid3, 0);
    ready3 = 0;
    start3 = 0;
    step();

    run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           20, "backpressure");
    repeat (4)
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             0, "random");

    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    gq = '{a, b, c};
    p0 = pulses;
    start = 1;
    step();
    k = 1;
    while (!out_valid && k < 100) begin
      start = ~start;
      step();
      k++;
    end
    repeat (3) begin
      start = ~start;
      step();
    end
    start = 0;
    step();
    start = 1;
    out_ready = 1;
    step();
    out_ready = 0;
    chk("retrig_sum", sum_out, (int'(a) / 3 + int'(b) / 3 + int'(c) / 3));
    bad = 0;
    repeat (10) begin
      step();
      if (busy) bad++;
    end
    chk("retrig_no_restart", bad, 0);
    chk("retrig_pulses", pulses - p0, 3);
    start = 0;
    step();

    gq = '{8'd100, 8'd110, 8'd120};
    p0 = pulses;
    start = 1;
    step();
    start = 0;
    k = 0;
    while (pulses - p0 < 2 && k < 100) begin
      step();
      k++;
    end
    chk("midrst_reached_wait", pulses - p0, 2);
    v0 = vseen;
    #2 rst = 0;
    #1;
    chk("midrst_async", {rng_start, out_valid, busy, sample_cnt, div_dividend, sum_out}, 0);
    step();
    step();
    gq.delete();
    rst = 1;
    repeat (12) step();
    chk("midrst_no_valid", vseen - v0, 0);
    chk("midrst_idle", busy, 0);
    run_op(8'd3, 8'd6, 8'd9, 0, "fresh");

    chk("pulse_width", wide, 0);
    chk("pulse_outside_req", stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
